// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder
//
// Memory-mapped timer and scratch register on the CPU memory port. It decodes a
// 32-byte window at BASE_ADDR, accepts full-word writes at the clock edge, and
// returns registered read data one cycle after the address. The timer counts
// prescaled clock ticks, compares against COMPARE, optionally auto-reloads, and
// raises sticky MATCH/WRAP flags that can drive an interrupt.
//
// Build option:
//   MMIO_CYCCNT_EN  adds a free-running cycle counter readable at offset 0x14.
//                   When it is not defined, offset 0x14 reads 0.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous active-high reset
//   addr    in   32  byte address; bits [1:0] ignored
//   mem_wr  in   1   1 = write, 0 = read
//   wdata   in   32  store data
//   sel     out  1   combinational window decode
//   rdata   out  32  registered read data
//   rd_hit  out  1   rdata belongs to this block this cycle
//   irq     out  1   registered interrupt request
//
// Register map (offset = addr[4:2]*4):
//   0x00 CTRL     bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
//   0x04 COUNT    read/write
//   0x08 COMPARE  read/write
//   0x0C STATUS   bit0 MATCH, bit1 WRAP, write-1-to-clear
//   0x10 SCRATCH  read/write
//   0x14 CYCCNT   read-only (optional)
//   0x18, 0x1C    read 0, writes ignored

module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_wr,
  input  logic [31:0] wdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        rd_hit,
  output logic        irq
);

  // PRESCALE is limited to 1..256, so the prescaler fits in 8 bits.
  localparam logic [7:0] PCNT_LAST = 8'(PRESCALE - 1);

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] compare;
  logic [1:0]  status;
  logic [31:0] scratch;
  logic [7:0]  pcnt;

  logic        wr_en;
  logic        rd_en;
  logic [2:0]  reg_idx;
  logic        ctrl_wr;
  logic        count_wr;
  logic        compare_wr;
  logic        status_wr;
  logic        scratch_wr;
  logic        tick;
  logic        count_eq_cmp;
  logic        count_max;
  logic        match_set;
  logic        wrap_set;
  logic [1:0]  w1c_mask;
  logic [1:0]  status_next;
  logic [31:0] count_next;
  logic [7:0]  pcnt_next;
  logic [31:0] read_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign sel     = (addr[31:5] == BASE_ADDR[31:5]);
  assign wr_en   = sel && mem_wr;
  assign rd_en   = sel && !mem_wr;
  assign reg_idx = addr[4:2];

  assign ctrl_wr    = wr_en && (reg_idx == 3'd0);
  assign count_wr   = wr_en && (reg_idx == 3'd1);
  assign compare_wr = wr_en && (reg_idx == 3'd2);
  assign status_wr  = wr_en && (reg_idx == 3'd3);
  assign scratch_wr = wr_en && (reg_idx == 3'd4);

  assign tick         = ctrl[0] && (pcnt == PCNT_LAST);
  // Comparison always uses the pre-edge COMPARE, so a same-cycle COMPARE write
  // only affects later ticks.
  assign count_eq_cmp = (count == compare);
  assign count_max    = (count == 32'hFFFF_FFFF);

  // Timer next-state. A software COUNT write discards the whole tick, including
  // any flag it would have raised.
  always_comb begin
    count_next = count;
    match_set  = 1'b0;
    wrap_set   = 1'b0;
    if (count_wr) begin
      count_next = wdata;
    end else if (tick) begin
      match_set = count_eq_cmp;
      if (count_eq_cmp && ctrl[1]) begin
        count_next = '0;
      end else begin
        count_next = count + 32'd1;
        wrap_set   = count_max;
      end
    end
  end

  // Hardware set is OR-ed in after the W1C mask so a same-cycle set wins.
  always_comb begin
    w1c_mask    = status_wr ? wdata[1:0] : 2'b00;
    status_next = (status & ~w1c_mask) | {wrap_set, match_set};
  end

  always_comb begin
    pcnt_next = pcnt;
    if (ctrl_wr || tick) begin
      pcnt_next = '0;
    end else if (ctrl[0]) begin
      pcnt_next = pcnt + 8'd1;
    end
  end

`ifdef MMIO_CYCCNT_EN
  logic [31:0] cyccnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyccnt <= '0;
    end else begin
      cyccnt <= cyccnt + 32'd1;
    end
  end
`endif

  always_comb begin
    read_val = '0;
    unique case (reg_idx)
      3'd0: read_val = {29'd0, ctrl};
      3'd1: read_val = count;
      3'd2: read_val = compare;
      3'd3: read_val = {30'd0, status};
      3'd4: read_val = scratch;
`ifdef MMIO_CYCCNT_EN
      3'd5: read_val = cyccnt;
`else
      3'd5: read_val = '0;
`endif
      default: read_val = '0;
    endcase
  end

  // irq samples the current STATUS/CTRL, so it follows a flag by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      status  <= '0;
      scratch <= '0;
      pcnt    <= '0;
      rdata   <= '0;
      rd_hit  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= wdata[2:0];
      end
      if (compare_wr) begin
        compare <= wdata;
      end
      if (scratch_wr) begin
        scratch <= wdata;
      end
      count  <= count_next;
      status <= status_next;
      pcnt   <= pcnt_next;
      if (rd_en) begin
        rdata <= read_val;
      end
      rd_hit <= rd_en;
      irq    <= |(status & {2{ctrl[2]}});
    end
  end

endmodule
